// File: rtl/m_stage_merge.sv
// m_stage_merge: two-input round-robin merge in front of the branch stage.
// Port a carries ring-return traffic, port b carries external injection.
// Each input and the output use a four-phase Send/Ack handshake:
//   a sender raises Send with stable data, the receiver raises Ack,
//   the sender drops Send, and then the receiver drops Ack.
// Packets are forwarded bit-for-bit through a single output register.
// Handshake outputs and Busy are registered alongside the FSM state.
module m_stage_merge #(
  parameter int PACKET_W = 38,
  parameter int CNT_W    = 16
) (
  input  logic                CP,
  input  logic                MR_n,
  input  logic                Send_in_a,
  input  logic [PACKET_W-1:0] PACKET_IN_a,
  output logic                Ack_out_a,
  input  logic                Send_in_b,
  input  logic [PACKET_W-1:0] PACKET_IN_b,
  output logic                Ack_out_b,
  output logic                Send_out,
  output logic [PACKET_W-1:0] PACKET_OUT,
  input  logic                Ack_in,
  output logic                Busy,
  output logic [CNT_W-1:0]    Cnt_a,
  output logic [CNT_W-1:0]    Cnt_b
);

  typedef enum logic [1:0] {O_IDLE, O_SEND, O_RTZ} o_state_t;
  typedef enum logic {I_IDLE, I_ACK} i_state_t;

  o_state_t o_state;
  i_state_t a_state;
  i_state_t b_state;
  logic     last_b;   // 1: port b won the most recent tie

  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;

  // A port requests only from I_IDLE so a held Send is never captured twice;
  // grants are issued only while the output register is empty.
  always_comb begin
    req_a   = Send_in_a && (a_state == I_IDLE);
    req_b   = Send_in_b && (b_state == I_IDLE);
    grant_a = (o_state == O_IDLE) && req_a && (!req_b || last_b);
    grant_b = (o_state == O_IDLE) && req_b && (!req_a || !last_b);
  end

  // Output FSM, output register, arbitration pointer, input FSMs and counters.
  always_ff @(posedge CP) begin
    if (!MR_n) begin
      o_state    <= O_IDLE;
      a_state    <= I_IDLE;
      b_state    <= I_IDLE;
      last_b     <= 1'b1;
      PACKET_OUT <= '0;
      Send_out   <= 1'b0;
      Busy       <= 1'b0;
      Ack_out_a  <= 1'b0;
      Ack_out_b  <= 1'b0;
      Cnt_a      <= '0;
      Cnt_b      <= '0;
    end else begin
      case (o_state)
        O_IDLE: begin
          if (grant_a || grant_b) begin
            o_state    <= O_SEND;
            Send_out   <= 1'b1;
            Busy       <= 1'b1;
            PACKET_OUT <= grant_a ? PACKET_IN_a : PACKET_IN_b;
          end
        end
        O_SEND: begin
          if (Ack_in) begin
            o_state  <= O_RTZ;
            Send_out <= 1'b0;
          end
        end
        O_RTZ: begin
          if (!Ack_in) begin
            o_state <= O_IDLE;
            Busy    <= 1'b0;
          end
        end
        default: begin
          o_state  <= O_IDLE;
          Send_out <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase

      // The pointer only moves when both ports compete.
      if (req_a && req_b && (grant_a || grant_b)) begin
        last_b <= grant_b;
      end

      case (a_state)
        I_IDLE: begin
          if (grant_a) begin
            a_state   <= I_ACK;
            Ack_out_a <= 1'b1;
            Cnt_a     <= Cnt_a + CNT_W'(1);
          end
        end
        default: begin
          if (!Send_in_a) begin
            a_state   <= I_IDLE;
            Ack_out_a <= 1'b0;
          end
        end
      endcase

      case (b_state)
        I_IDLE: begin
          if (grant_b) begin
            b_state   <= I_ACK;
            Ack_out_b <= 1'b1;
            Cnt_b     <= Cnt_b + CNT_W'(1);
          end
        end
        default: begin
          if (!Send_in_b) begin
            b_state   <= I_IDLE;
            Ack_out_b <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/m_stage_merge.md
Name: m_stage_merge

Overview:
- Synchronous two-input merge stage directly upstream of the branch stage.
- Joins the ring-return stream (port a) and the external/injection stream (port b) into the single 38-bit packet stream that the branch stage consumes.
- Uses the same Send/Ack four-phase handshake as the branch stage; packet content is forwarded unchanged.
- Round-robin arbitration, a one-packet output register, and per-port forwarded-packet counters for debug.

Parameters:
- PACKET_W, 38, packet width in bits; bit map matches the pipeline (dest [26:20], MF [19], BR [18]).
- CNT_W, 16, width of each forwarded-packet counter.

Ports:
- CP  input  1  clock; all state changes on the rising edge.
- MR_n  input  1  master reset, synchronous, active-low.
- Send_in_a  input  1  port a request; PACKET_IN_a is valid while high.
- PACKET_IN_a  input  PACKET_W  port a packet.
- Ack_out_a  output  1  port a acknowledge.
- Send_in_b  input  1  port b request.
- PACKET_IN_b  input  PACKET_W  port b packet.
- Ack_out_b  output  1  port b acknowledge.
- Send_out  output  1  request to the downstream (branch) stage.
- PACKET_OUT  output  PACKET_W  registered packet; stable while Send_out is high.
- Ack_in  input  1  downstream acknowledge.
- Busy  output  1  high whenever the output register holds an undelivered packet (output FSM not in O_IDLE).
- Cnt_a  output  CNT_W  packets accepted from port a.
- Cnt_b  output  CNT_W  packets accepted from port b.

Behaviour:
- Reset, sampled on the CP edge with MR_n=0:
  - Output FSM goes to O_IDLE; both input FSMs go to I_IDLE.
  - PACKET_OUT=0; Send_out, Ack_out_a, Ack_out_b and Busy are 0.
  - Cnt_a=Cnt_b=0; round-robin pointer last=b, so port a wins the first tie.
  - Reset has priority over every other event. A transfer in flight is discarded and no output holds its value.
- Input FSM, per port x:
  - I_IDLE: Ack_out_x=0.
  - I_IDLE -> I_ACK on the edge where port x is granted.
  - I_ACK: Ack_out_x=1; stays until Send_in_x is sampled 0, then returns to I_IDLE.
  - Port x requests only when Send_in_x=1 and its FSM is in I_IDLE, so a held Send is never captured twice.
- Grant and capture, evaluated only when the output FSM is in O_IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to last is granted; last is then updated to the granted port.
  - On grant, the same edge does all of: PACKET_OUT <= PACKET_IN_x; output FSM -> O_SEND; input FSM x -> I_ACK; Cnt_x increments.
  - Cnt_x wraps modulo 2^CNT_W with no saturation.
  - Latency: Send_in_x sampled high at edge t gives Send_out=1 and Ack_out_x=1 together after edge t.
- Output FSM:
  - O_IDLE: Send_out=0.
  - O_SEND: Send_out=1; goes to O_RTZ on the first edge where Ack_in=1.
  - O_RTZ: Send_out=0; goes to O_IDLE on the first edge where Ack_in=0.
  - PACKET_OUT changes only on capture; it holds through O_SEND and O_RTZ.
  - Busy=1 in O_SEND and O_RTZ.
- Boundary rules:
  - Output occupied (not O_IDLE): no grant; requesters wait, with Ack_out held 0.
  - Ack_in=1 while in O_IDLE: ignored.
  - Send_in_x withdrawn before grant: no capture, no error.
  - Port in I_ACK with Send_in_x still high: not eligible. The other port may be granted if the output is idle.
  - Ack_in stuck at 1: the stage stalls in O_RTZ indefinitely.
  - Throughput: at most one packet per 4 cycles with a downstream that acknowledges in one cycle.
  - Reset mid-operation: if Send_in_x is still high after reset, the packet is re-captured as a new request. Upstream stages share MR_n and must clear with it.
- Data integrity: PACKET_OUT is bit-identical to the captured input, including MF and BR; no field is modified.

Test Plan:
- Single transfer on port a:
  - Stimulus: PACKET_IN_a=38'h00_0030_0001 (dest=3, BR=0), Send_in_a=1; downstream acks 1 cycle after Send_out.
  - Required: Send_out and Ack_out_a rise together one edge after Send_in_a is sampled; PACKET_OUT matches exactly; Cnt_a=1, Cnt_b=0.
- Simultaneous requests after reset:
  - Stimulus: a=38'h1, b=38'h2, both Send high, responsive downstream.
  - Required: delivery order is a then b; next tie with a=38'h3, b=38'h4 delivers b first; Cnt_a=Cnt_b=2.
- Backpressure:
  - Stimulus: hold Ack_in=0 for 20 cycles after Send_out rises, with port b requesting during that time.
  - Required: Send_out stays 1, PACKET_OUT stays stable, Ack_out_b stays 0, Busy=1; port b is captured only after the Ack_in 1->0 cycle completes.
- Held Send:
  - Stimulus: port a keeps Send_in_a=1 for 10 cycles after Ack_out_a rises.
  - Required: exactly one capture; Cnt_a=1; Ack_out_a falls one edge after Send_in_a is sampled 0.
- Reset mid-transfer:
  - Stimulus: assert MR_n=0 for one edge while in O_SEND.
  - Required: next cycle all outputs are 0 and Cnt_a=Cnt_b=0; a re-asserted Send_in_a is accepted normally.
- Counter wrap:
  - Stimulus: CNT_W=4, send 17 packets on port b.
  - Required: Cnt_b=1.
